// File: rtl/nr4sdp_seq_mult.sv
// Sequential signed multiplier. The multiplicand is recoded into non-redundant radix-4
// signed digits (NR4SD+, top digit modified-Booth style). DPC digits are retired per
// cycle into a 2*WIDTH accumulator under a start/busy/done handshake.
module nr4sdp_seq_mult #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DPC   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned K  = WIDTH / 2;
  localparam int unsigned L  = K / DPC;
  localparam int unsigned CW = (L > 1) ? $clog2(L) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam logic [CW-1:0] LastIt = CW'(L - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [PW-1:0]   b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  logic [PW-1:0]   pp_sum;
  logic            c_out;

  // Recode the next DPC digits (carry chained) and sum their shifted partial products.
  always_comb begin : recode
    logic          carry;
    logic [2:0]    s;
    logic [2:0]    dig;
    logic [PW-1:0] b_sh;
    carry  = c_q;
    pp_sum = '0;
    s      = '0;
    dig    = '0;
    b_sh   = '0;
    for (int j = 0; j < int'(DPC); j++) begin
      dig  = '0;
      s    = {1'b0, a_q[2*j+1], a_q[2*j]} + {2'b00, carry};
      b_sh = b_q << (2 * j);
      if (cnt_q == LastIt && j == int'(DPC) - 1) begin
        // Top digit: -2*a1 + a0 + c == s - 4*a1, i.e. s + 4*a1 modulo 8.
        dig   = s + {a_q[2*j+1], 2'b00};
        carry = 1'b0;
      end else begin
        case (s)
          3'd3:    begin dig = 3'b111; carry = 1'b1; end
          3'd4:    begin dig = 3'b000; carry = 1'b1; end
          default: begin dig = s;      carry = 1'b0; end
        endcase
      end
      case (dig)
        3'b001:  pp_sum = pp_sum + b_sh;
        3'b010:  pp_sum = pp_sum + (b_sh << 1);
        3'b111:  pp_sum = pp_sum + (~b_sh + PW'(1));
        3'b110:  pp_sum = pp_sum + ((~b_sh + PW'(1)) << 1);
        default: pp_sum = pp_sum;
      endcase
    end
    c_out = carry;
  end

  // Next-state: load on start in idle, accumulate while running, publish on last iteration.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = {{WIDTH{b[WIDTH-1]}}, b};
          acc_d   = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_q + pp_sum;
        a_d   = a_q >> (2 * DPC);
        b_d   = b_q << (2 * DPC);
        c_d   = c_out;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIt) begin
          prod_d  = acc_q + pp_sum;
          done_d  = 1'b1;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_nr4sdp_seq_mult.sv
// Bench for nr4sdp_seq_mult: directed vector table on WIDTH=16/DPC=1, handshake corner
// cases, and back-to-back random streams on WIDTH=16/DPC=2 and WIDTH=8/DPC=4.
module tb_nr4sdp_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start;
  logic [15:0] a, b;
  logic        busy, done;
  logic [31:0] product;

  logic        start2, busy2, done2;
  logic [15:0] a2, b2;
  logic [31:0] p2;

  logic        start3, busy3, done3;
  logic [7:0]  a3, b3;
  logic [15:0] p3;

  nr4sdp_seq_mult #(.WIDTH(16), .DPC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );
  nr4sdp_seq_mult #(.WIDTH(16), .DPC(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .product(p2)
  );
  nr4sdp_seq_mult #(.WIDTH(8), .DPC(4)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .product(p3)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last2 = -1;
  int last3 = -1;
  logic [31:0] exp_q[$];
  logic [31:0] q2[$];
  logic [15:0] q3[$];

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] vp;
  } vec_t;
  vec_t vecs[9];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboards: every done pops the oldest expected product.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 with product 0x%0h want no done", product);
      end else check("product", {32'h0, product}, {32'h0, exp_q.pop_front()});
    end
    if (rst_n && done2) begin
      if (last2 >= 0) check("interval_dpc2", 64'(cyc - last2), 64'd5);
      last2 = cyc;
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done_dpc2: got done=1 want no done");
      end else check("product_dpc2", {32'h0, p2}, {32'h0, q2.pop_front()});
    end
    if (rst_n && done3) begin
      if (last3 >= 0) check("interval_w8", 64'(cyc - last3), 64'd2);
      last3 = cyc;
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done_w8: got done=1 want no done");
      end else check("product_w8", {48'h0, p3}, {48'h0, q3.pop_front()});
    end
  end

  // One operation on the main instance; optionally pulses start again mid-run at poke.
  task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] ev,
                       input int poke);
    int n;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    exp_q.push_back(ev);
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = ~bv;
    check("busy_after_start", {63'h0, busy}, 64'd1);
    n = 1;
    while (!done && n < 20) begin
      if (n == poke) begin
        a = 16'h1111; b = 16'h2222; start = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check("latency", 64'(n), 64'd9);
    check("busy_at_done", {63'h0, busy}, 64'd1 - 64'(done));
    @(negedge clk);
    check("done_pulse_width", {63'h0, done}, 64'd0);
    check("product_hold", {32'h0, product}, {32'h0, ev});
  endtask

  task automatic run_rand2(input int n_ops);
    int issued = 0;
    int n = 0;
    logic signed [31:0] sa, sb;
    while (issued < n_ops) begin
      @(negedge clk);
      if (!busy2) begin
        a2 = 16'($urandom); b2 = 16'($urandom);
        sa = $signed(a2); sb = $signed(b2);
        q2.push_back(32'(sa * sb));
        start2 = 1'b1;
        issued++;
      end
    end
    @(negedge clk);
    start2 = 1'b0;
    while (q2.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_dpc2", 64'(q2.size()), 64'd0);
  endtask

  task automatic run_rand3(input int n_ops);
    int issued = 0;
    int n = 0;
    logic signed [15:0] sa, sb;
    while (issued < n_ops) begin
      @(negedge clk);
      if (!busy3) begin
        a3 = 8'($urandom); b3 = 8'($urandom);
        sa = $signed(a3); sb = $signed(b3);
        q3.push_back(16'(sa * sb));
        start3 = 1'b1;
        issued++;
      end
    end
    @(negedge clk);
    start3 = 1'b0;
    while (q3.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_w8", 64'(q3.size()), 64'd0);
  endtask

  initial begin
    int d0;
    vecs[0] = '{16'h0B1E, 16'h3E51, 32'd45402238};
    vecs[1] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[2] = '{16'hFFFF, 16'h7FFF, 32'hFFFF_8001};
    vecs[3] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'hFFFF_FFFF};
    vecs[5] = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
    vecs[6] = '{16'h8000, 16'h7FFF, 32'hC000_8000};
    vecs[7] = '{16'h5555, 16'h0003, 32'h0000_FFFF};
    vecs[8] = '{16'hFFFD, 16'hFFFB, 32'h0000_000F};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start2 = 1'b0; a2 = '0; b2 = '0;
    start3 = 1'b0; a3 = '0; b3 = '0;
    #12;
    check("reset_busy", {63'h0, busy}, 64'd0);
    check("reset_done", {63'h0, done}, 64'd0);
    check("reset_product", {32'h0, product}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) do_op(vecs[i].va, vecs[i].vb, vecs[i].vp, 0);

    // Start pulsed mid-run with other operands must be ignored.
    d0 = done_cnt;
    do_op(16'h0B1E, 16'h3E51, 32'd45402238, 3);
    repeat (12) @(negedge clk);
    check("single_done", 64'(done_cnt - d0), 64'd1);

    // Asynchronous reset mid-run: outputs clear at once, no done for the aborted op.
    d0 = done_cnt;
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", {63'h0, busy}, 64'd0);
    check("abort_done", {63'h0, done}, 64'd0);
    check("abort_product", {32'h0, product}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    do_op(16'hFFFD, 16'h0B1E, 32'hFFFF_DEA6, 0);

    fork
      run_rand2(10000);
      run_rand3(10000);
    join

    check("main_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
